// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word reads to instruction memory and hands {instr, instr_pc} to decode.
// Response to instr_valid is one cycle; a redirect flushes the output FIFO and drops stale in-flight words.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [AW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

  logic [31:0]   pcq_q        [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_pc_q    [DEPTH];

  logic [CW:0]   inuse;
  logic          credit_ok;
  logic          issue_hs;
  logic          rsp_keep;
  logic          deq;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Dropped responses still hold their credit, so in-flight plus buffered never exceeds DEPTH.
  assign inuse     = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign credit_ok = (inuse < CREDITS);
  assign imem_req  = rst_n & credit_ok & ~redirect;
  assign imem_addr = fetch_pc_q;
  assign issue_hs  = imem_req & imem_gnt;
  assign rsp_keep  = imem_rvalid & ~redirect & (drop_q == '0);

  assign instr_valid = (fifo_cnt_q != '0);
  assign instr       = fifo_instr_q[fifo_rd_q];
  assign instr_pc    = fifo_pc_q[fifo_rd_q];
  assign deq         = instr_valid & instr_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    outst_d    = outst_q + CW'(issue_hs) - CW'(imem_rvalid);
    pcq_wr_d   = pcq_wr_q + AW'(issue_hs);
    pcq_rd_d   = pcq_rd_q + AW'(imem_rvalid);

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = outst_d;
      fifo_cnt_d = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
    end else begin
      if (issue_hs) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(rsp_keep) - CW'(deq);
      fifo_wr_d  = fifo_wr_q + AW'(rsp_keep);
      fifo_rd_d  = fifo_rd_q + AW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      fifo_cnt_q <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      fifo_cnt_q <= fifo_cnt_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
    end
  end

  // The PC queue runs in lockstep with responses, including dropped ones, so its order never needs repair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcq_q[i]        <= '0;
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      if (issue_hs) begin
        pcq_q[pcq_wr_q] <= fetch_pc_q;
      end
      if (rsp_keep) begin
        fifo_instr_q[fifo_wr_q] <= imem_rdata;
        fifo_pc_q[fifo_wr_q]    <= pcq_q[pcq_rd_q];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a one-cycle-latency memory model with stall controls feeds the DUT.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rsp_hold;
  logic [31:0] mem_q [$];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory: accepts on req&gnt, answers in order one cycle later unless rsp_hold stalls it.
  initial begin
    logic        hs;
    logic [31:0] hs_addr;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      hs      = rst_n && imem_req && imem_gnt;
      hs_addr = imem_addr;
      if (rst_n && imem_rvalid) begin
        n_cmp++;
        if (dut.fifo_cnt_q === 2'd2) begin
          n_bad++;
          $display("FAIL rvalid_into_full_fifo: fifo count %0d, required below 2", dut.fifo_cnt_q);
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_q.delete();
        imem_rvalid = 1'b0;
      end else begin
        if (hs) mem_q.push_back(hs_addr);
        if (!rsp_hold && mem_q.size() > 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word_of(mem_q.pop_front());
        end else begin
          imem_rvalid = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    rsp_hold    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    repeat (2) step();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b required 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b required 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h required 0", instr); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h required 0", instr_pc); end
    imem_gnt    = 1'b1;
    instr_ready = 1'b1;
    rst_n       = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [4];
    int idx   = 0;
    int first = -1;
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int cyc = 1; cyc <= 20 && idx < 4; cyc++) begin
      step();
      if (instr_valid) begin
        if (first < 0) first = cyc;
        n_cmp++;
        if (instr_pc !== exp_pc[idx]) begin n_bad++; $display("FAIL stream_pc[%0d]: got %h required %h", idx, instr_pc, exp_pc[idx]); end
        n_cmp++;
        if (instr !== word_of(exp_pc[idx])) begin n_bad++; $display("FAIL stream_instr[%0d]: got %h required %h", idx, instr, word_of(exp_pc[idx])); end
        idx++;
        if (idx == 4) imem_gnt = 1'b0;
      end
    end
    n_cmp++; if (idx != 4) begin n_bad++; $display("FAIL stream_timeout: got %0d instrs required 4", idx); end
    n_cmp++; if (first != 2) begin n_bad++; $display("FAIL stream_fill: first valid at cycle %0d required 2", first); end
  endtask

  task automatic test_gnt_stall();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL stall_req[%0d]: got %b required 1", i, imem_req); end
      n_cmp++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h required 10", i, imem_addr); end
    end
    imem_gnt = 1'b1;
    step();
    n_cmp++; if (imem_addr !== 32'h14) begin n_bad++; $display("FAIL stall_advance: got %h required 14", imem_addr); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [2];
    int idx = 0;
    exp_pc = '{32'h18, 32'h1C};
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b required 1", i, instr_valid); end
      n_cmp++; if (instr_pc !== 32'h10) begin n_bad++; $display("FAIL bp_pc[%0d]: got %h required 10", i, instr_pc); end
      n_cmp++; if (instr !== word_of(32'h10)) begin n_bad++; $display("FAIL bp_instr[%0d]: got %h required %h", i, instr, word_of(32'h10)); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req[%0d]: got %b required 0", i, imem_req); end
    end
    instr_ready = 1'b1;
    #1;
    n_cmp++; if (instr_pc !== 32'h10) begin n_bad++; $display("FAIL bp_resume0: got %h required 10", instr_pc); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h14) begin n_bad++; $display("FAIL bp_resume1: got valid %b pc %h required 1 14", instr_valid, instr_pc); end
    for (int cyc = 0; cyc < 10 && idx < 2; cyc++) begin
      step();
      if (instr_valid) begin
        n_cmp++;
        if (instr_pc !== exp_pc[idx]) begin n_bad++; $display("FAIL bp_next[%0d]: got %h required %h", idx, instr_pc, exp_pc[idx]); end
        idx++;
        if (idx == 2) imem_gnt = 1'b0;
      end
    end
    n_cmp++; if (idx != 2) begin n_bad++; $display("FAIL bp_timeout: got %0d instrs required 2", idx); end
    step();
  endtask

  task automatic test_redirect_inflight();
    logic seen_req = 1'b0;
    logic got      = 1'b0;
    rsp_hold = 1'b1;
    imem_gnt = 1'b1;
    repeat (3) step();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rd_credit: got req %b required 0", imem_req); end
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    rsp_hold = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rd_flush: got valid %b required 0", instr_valid); end
    for (int cyc = 0; cyc < 15 && !got; cyc++) begin
      if (!seen_req && imem_req) begin
        seen_req = 1'b1;
        n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL rd_addr: got %h required 100", imem_addr); end
      end
      if (instr_valid) begin
        got = 1'b1;
        n_cmp++; if (instr_pc !== 32'h100) begin n_bad++; $display("FAIL rd_pc: got %h required 100", instr_pc); end
        n_cmp++; if (instr !== word_of(32'h100)) begin n_bad++; $display("FAIL rd_instr: got %h required %h", instr, word_of(32'h100)); end
      end else begin
        step();
      end
    end
    n_cmp++; if (!(seen_req && got)) begin n_bad++; $display("FAIL rd_timeout: got req %b valid %b required 1 1", seen_req, got); end
    imem_gnt = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_redirect_collision();
    imem_gnt = 1'b1;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL col_req: got %b required 0", imem_req); end
    step();
    redirect = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL col_stale0: got valid %b required 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_bad++; $display("FAIL col_addr: got req %b addr %h required 1 200", imem_req, imem_addr); end
    step();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL col_stale1: got valid %b required 0", instr_valid); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin n_bad++; $display("FAIL col_first: got valid %b pc %h required 1 200", instr_valid, instr_pc); end
    n_cmp++; if (instr !== word_of(32'h200)) begin n_bad++; $display("FAIL col_instr: got %h required %h", instr, word_of(32'h200)); end
  endtask

  task automatic test_back_to_back();
    logic seen_req = 1'b0;
    logic got      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h400;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL b2b_req: got %b required 0", imem_req); end
    step();
    redirect = 1'b0;
    #1;
    for (int cyc = 0; cyc < 15 && !got; cyc++) begin
      if (!seen_req && imem_req) begin
        seen_req = 1'b1;
        n_cmp++; if (imem_addr !== 32'h400) begin n_bad++; $display("FAIL b2b_addr: got %h required 400", imem_addr); end
      end
      if (instr_valid) begin
        got = 1'b1;
        n_cmp++; if (instr_pc !== 32'h400) begin n_bad++; $display("FAIL b2b_pc: got %h required 400", instr_pc); end
      end else begin
        step();
      end
    end
    n_cmp++; if (!(seen_req && got)) begin n_bad++; $display("FAIL b2b_timeout: got req %b valid %b required 1 1", seen_req, got); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] exp_pc [2];
    int nreq = 0;
    int nval = 0;
    exp_pc = '{32'hFFFF_FFFC, 32'h0000_0000};
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    #1;
    for (int cyc = 0; cyc < 20 && nval < 2; cyc++) begin
      if (imem_req && imem_gnt && nreq < 2) begin
        n_cmp++; if (imem_addr !== exp_pc[nreq]) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %h required %h", nreq, imem_addr, exp_pc[nreq]); end
        nreq++;
      end
      if (instr_valid) begin
        n_cmp++; if (instr_pc !== exp_pc[nval]) begin n_bad++; $display("FAIL wrap_pc[%0d]: got %h required %h", nval, instr_pc, exp_pc[nval]); end
        nval++;
      end
      if (nval < 2) step();
    end
    n_cmp++; if (nreq != 2 || nval != 2) begin n_bad++; $display("FAIL wrap_timeout: got %0d reqs %0d instrs required 2 2", nreq, nval); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b required 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL midrst_req: got %b required 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_addr: got %h required 0", imem_addr); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL midrst_pc: got %h required 0", instr_pc); end
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gnt_stall();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_back_to_back();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
